// File: rtl/genbus_pkg.sv
// rtl/genbus_pkg.sv - shared FSM state, widths and byte-mask helper for the genbus master
package genbus_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Expands byte enables into a data-width mask so disabled lanes read back as zero.
  function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < BE_W; i++) begin
      m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/genbus_wdog.sv
// rtl/genbus_wdog.sv - wait-state counter that flags an access stuck longer than TIMEOUT cycles
module genbus_wdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ws,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating so a disabled timeout never wraps back into a false match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ws && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && ws && (cnt_q == LIMIT);

endmodule

// File: rtl/genbus_master.sv
// rtl/genbus_master.sv - single-outstanding genbus master with wait states and timeout abort
module genbus_master
  import genbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned ADR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADR_W-1:0]  cmd_adr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [BE_W-1:0]   cmd_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] mdata,
  output logic [BE_W-1:0]   we,
  output logic [BE_W-1:0]   re,
  input  logic [DATA_W-1:0] sdata,
  input  logic              ws
);

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BE_W-1:0]   we_q, we_d;
  logic [BE_W-1:0]   re_q, re_d;
  logic              err_q, err_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              expired;

  genbus_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != ST_ACCESS),
    .ws     (ws),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      be_q        <= '0;
      adr_q       <= '0;
      mdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= '0;
      re_q        <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      adr_q       <= adr_d;
      mdata_q     <= mdata_d;
      rdata_q     <= rdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (cmd_valid) state_d = ST_ACCESS;
      ST_ACCESS: if (!ws || expired) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobes are rebuilt every cycle from the latched command so they fall to zero on any exit.
  always_comb begin
    wr_d        = wr_q;
    be_d        = be_q;
    adr_d       = adr_q;
    mdata_d     = mdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    we_d        = '0;
    re_d        = '0;
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          be_d    = cmd_be;
          adr_d   = cmd_adr;
          mdata_d = cmd_wdata;
          we_d    = cmd_write ? cmd_be : '0;
          re_d    = cmd_write ? '0 : cmd_be;
        end
      end
      ST_ACCESS: begin
        if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (ws) begin
          we_d = we_q;
          re_d = re_q;
        end else begin
          rdata_d = wr_q ? '0 : (sdata & be_mask(be_q));
          err_d   = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign adr       = adr_q;
  assign mdata     = mdata_q;
  assign we        = we_q;
  assign re        = re_q;

endmodule

// File: tb/tb_genbus_master.sv
// tb/tb_genbus_master.sv - randomized transaction-level bench for genbus_master
module tb_genbus_master;

  localparam int TIMEOUT = 15;
  localparam int ADR_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADR_W-1:0]  cmd_adr;
  logic [15:0]       cmd_wdata;
  logic [1:0]        cmd_be;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [15:0]       rsp_rdata;
  logic [ADR_W-1:0]  adr;
  logic [15:0]       mdata, sdata;
  logic [1:0]        we, re;
  logic              ws;

  genbus_master #(.TIMEOUT(TIMEOUT), .ADR_W(ADR_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .adr(adr), .mdata(mdata), .we(we), .re(re), .sdata(sdata), .ws(ws)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expected outputs for the current cycle, written by the stimulus thread.
  bit              chk_en = 1'b0;
  bit              rsp_chk;
  logic            exp_ready, exp_valid, exp_err;
  logic [1:0]      exp_we, exp_re;
  logic [ADR_W-1:0] exp_adr, last_adr;
  logic [15:0]     exp_mdata, exp_rdata, last_mdata;

  // Free-running observations used by the literal checks.
  int              mon_strobes = 0;
  int              mon_rise = 0;
  bit              mon_prev = 1'b0;
  logic [15:0]     mon_rdata = '0;
  logic            mon_err = 1'b0;
  int              acc_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("we", 32'(we), 32'(exp_we));
      chk("re", 32'(re), 32'(exp_re));
      chk("adr", 32'(adr), 32'(exp_adr));
      chk("mdata", 32'(mdata), 32'(exp_mdata));
      if (rsp_chk) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
    end
    if (we != 2'b00 || re != 2'b00) mon_strobes = mon_strobes + 1;
    if (rsp_valid && !mon_prev) mon_rise = cyc;
    if (rsp_valid) begin
      mon_rdata = rsp_rdata;
      mon_err   = rsp_err;
    end
    mon_prev = rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit cv);
    cmd_valid = cv;
    cmd_write = 1'($urandom);
    cmd_adr   = ADR_W'($urandom);
    cmd_wdata = 16'($urandom);
    cmd_be    = 2'($urandom);
  endtask

  task automatic idle_exp();
    exp_ready = 1'b1;
    exp_valid = 1'b0;
    exp_we    = 2'b00;
    exp_re    = 2'b00;
    exp_adr   = last_adr;
    exp_mdata = last_mdata;
    rsp_chk   = 1'b0;
  endtask

  // One full transaction: gap idle cycles, accept, w wait states, d cycles of rsp_ready low.
  task automatic txn(input bit wr, input logic [ADR_W-1:0] a, input logic [15:0] wd,
                     input logic [1:0] be, input int w, input int d, input int gap,
                     input logic [15:0] sd_fix, input bit sd_rand, input bit cv_hold);
    bit          err;
    int          ns;
    logic [15:0] rd;
    logic [15:0] mask;
    for (int g = 0; g < gap; g++) begin
      step();
      noise(1'b0);
      ws = 1'($urandom); sdata = 16'($urandom); rsp_ready = 1'($urandom);
      idle_exp();
    end
    step();
    cmd_valid = 1'b1; cmd_write = wr; cmd_adr = a; cmd_wdata = wd; cmd_be = be;
    ws = 1'($urandom); sdata = 16'($urandom); rsp_ready = 1'($urandom);
    idle_exp();
    acc_cyc    = cyc;
    last_adr   = a;
    last_mdata = wd;
    err  = (TIMEOUT != 0) && (w > TIMEOUT);
    ns   = err ? TIMEOUT + 1 : w + 1;
    mask = {{8{be[1]}}, {8{be[0]}}};
    rd   = 16'h0000;
    for (int k = 1; k <= ns; k++) begin
      step();
      noise(cv_hold ? 1'b1 : 1'($urandom));
      ws        = (k <= w);
      sdata     = sd_rand ? 16'($urandom) : sd_fix;
      rsp_ready = 1'($urandom);
      exp_ready = 1'b0;
      exp_valid = 1'b0;
      exp_we    = wr ? be : 2'b00;
      exp_re    = wr ? 2'b00 : be;
      exp_adr   = a;
      exp_mdata = wd;
      rsp_chk   = 1'b0;
      if (k == ns && !err && !wr) rd = sdata & mask;
    end
    for (int j = 0; j <= d; j++) begin
      step();
      noise(cv_hold ? 1'b1 : 1'($urandom));
      ws        = 1'($urandom);
      sdata     = 16'($urandom);
      rsp_ready = (j == d);
      exp_ready = 1'b0;
      exp_valid = 1'b1;
      exp_we    = 2'b00;
      exp_re    = 2'b00;
      exp_adr   = a;
      exp_mdata = wd;
      exp_rdata = rd;
      exp_err   = err;
      rsp_chk   = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_adr = '0; cmd_wdata = '0;
    cmd_be = 2'b00; rsp_ready = 1'b0; sdata = '0; ws = 1'b0;
    last_adr = '0; last_mdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_exp();
    exp_rdata = 16'h0000; exp_err = 1'b0; rsp_chk = 1'b1;
    chk_en = 1'b1;

    // Zero-wait read, full byte enables.
    s0 = mon_strobes;
    txn(1'b0, 16'h0001, 16'h5555, 2'b11, 0, 0, 1, 16'h00A5, 1'b0, 1'b0);
    settle();
    chk("rd_strobe_cycles", 32'(mon_strobes - s0), 32'd1);
    chk("rd_rdata", 32'(mon_rdata), 32'h00A5);
    chk("rd_err", 32'(mon_err), 32'd0);
    chk("rd_latency", 32'(mon_rise - acc_cyc), 32'd2);

    // Write with three wait states.
    s0 = mon_strobes;
    txn(1'b1, 16'h0000, 16'h1234, 2'b01, 3, 0, 0, 16'h0000, 1'b1, 1'b0);
    settle();
    chk("wr_strobe_cycles", 32'(mon_strobes - s0), 32'd4);
    chk("wr_err", 32'(mon_err), 32'd0);

    // Slave never releases ws: timeout abort.
    s0 = mon_strobes;
    txn(1'b0, 16'h00C3, 16'h0F0F, 2'b11, 40, 1, 0, 16'h0000, 1'b1, 1'b0);
    settle();
    chk("to_strobe_cycles", 32'(mon_strobes - s0), 32'd16);
    chk("to_err", 32'(mon_err), 32'd1);
    chk("to_rdata", 32'(mon_rdata), 32'h0000);

    // Back-pressured response with cmd_valid held, then an immediate follow-up.
    txn(1'b0, 16'h0777, 16'hAAAA, 2'b11, 1, 5, 0, 16'h3C3C, 1'b0, 1'b1);
    txn(1'b1, 16'h0778, 16'h9876, 2'b10, 0, 0, 0, 16'h0000, 1'b1, 1'b0);

    // Upper-byte-only read.
    txn(1'b0, 16'h0100, 16'h0000, 2'b10, 0, 1, 0, 16'hBEEF, 1'b0, 1'b0);
    settle();
    chk("be10_rdata", 32'(mon_rdata), 32'h0000BE00);

    // No byte enables: access happens without strobes.
    s0 = mon_strobes;
    txn(1'b0, 16'h0200, 16'h1111, 2'b00, 0, 0, 1, 16'hFFFF, 1'b0, 1'b0);
    settle();
    chk("be00_strobe_cycles", 32'(mon_strobes - s0), 32'd0);
    chk("be00_rdata", 32'(mon_rdata), 32'h0000);

    // Reset in the middle of a wait-stated read.
    step();
    noise(1'b1); cmd_write = 1'b0; cmd_adr = 16'h0042; cmd_wdata = 16'h6666; cmd_be = 2'b11;
    ws = 1'b0; rsp_ready = 1'b0;
    idle_exp();
    last_adr = 16'h0042; last_mdata = 16'h6666;
    for (int k = 0; k < 2; k++) begin
      step();
      cmd_valid = 1'b0; ws = 1'b1; sdata = 16'($urandom);
      exp_ready = 1'b0; exp_valid = 1'b0; exp_we = 2'b00; exp_re = 2'b11;
      exp_adr = 16'h0042; exp_mdata = 16'h6666; rsp_chk = 1'b0;
      if (k == 1) rst = 1'b1;
    end
    step();
    rst = 1'b0; ws = 1'b1;
    last_adr = '0; last_mdata = '0;
    idle_exp();
    exp_rdata = 16'h0000; exp_err = 1'b0; rsp_chk = 1'b1;

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      int w;
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TIMEOUT + 4))
                                      : int'($urandom_range(0, 3));
      txn(1'($urandom), ADR_W'($urandom), 16'($urandom), 2'($urandom), w,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          16'h0000, 1'b1, 1'($urandom));
    end
    step();
    noise(1'b0);
    idle_exp();
    step();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
